// File: rtl/srambank_arb_pkg.sv
// Shared types and constants for the srambank_128x4x74 two-requester arbiter.
package srambank_arb_pkg;

    localparam int unsigned SRAMBANK_ADDR_W = 9;
    localparam int unsigned SRAMBANK_DATA_W = 74;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_RUN
    } arb_state_e;

endpackage

// File: rtl/srambank_arb_128x4x74_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered priority pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prio_q;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After a grant, the other requester wins the next tie; idle cycles hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (grant[0]) begin
            prio_q <= 1'b1;
        end else if (grant[1]) begin
            prio_q <= 1'b0;
        end
    end

endmodule

// File: rtl/srambank_arb_128x4x74.sv
// Arbiter/sequencer for one srambank_128x4x74_6t122 bank shared by two requesters.
// Define SRAMBANK_ARB_INIT_EN to zero-fill the bank after every reset.
module srambank_arb_128x4x74
    import srambank_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAMBANK_ADDR_W,
    parameter int unsigned DATA_W = SRAMBANK_DATA_W,
    parameter int unsigned DEPTH  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic              sram_banksel,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_wd,
    input  logic [DATA_W-1:0] sram_dataout
);

    if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
        $error("DEPTH must equal 2**ADDR_W");
    end

    arb_state_e        state_q;
    logic              run;
    logic              init_active;
    logic [ADDR_W-1:0] init_addr;
    logic [1:0]        valid_run;
    logic [1:0]        grant;
    logic [1:0]        rsp_valid_q;

    // Gated by reset so every output sits at its idle value while reset is high.
    assign run       = (state_q == ST_RUN) && !reset;
    assign valid_run = run ? req_valid : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .valid (valid_run),
        .grant (grant)
    );

`ifdef SRAMBANK_ARB_INIT_EN
    logic [ADDR_W-1:0] init_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + ADDR_W'(1);
            if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_q <= ST_RUN;
            end
        end
    end

    assign init_active = (state_q == ST_INIT) && !reset;
    assign init_addr   = init_cnt_q;
`else
    always_ff @(posedge clk) begin
        state_q <= ST_RUN;
    end

    assign init_active = 1'b0;
    assign init_addr   = '0;
`endif

    always_comb begin
        sram_banksel = 1'b0;
        sram_read    = 1'b0;
        sram_write   = 1'b0;
        sram_address = '0;
        sram_wd      = '0;
        if (init_active) begin
            sram_banksel = 1'b1;
            sram_write   = 1'b1;
            sram_address = init_addr;
        end else if (grant[0]) begin
            sram_banksel = 1'b1;
            sram_write   = req_write[0];
            sram_read    = ~req_write[0];
            sram_address = req_addr0;
            sram_wd      = req_wdata0;
        end else if (grant[1]) begin
            sram_banksel = 1'b1;
            sram_write   = req_write[1];
            sram_read    = ~req_write[1];
            sram_address = req_addr1;
            sram_wd      = req_wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 2'b00;
        end else begin
            rsp_valid_q <= grant & ~req_write;
        end
    end

    assign req_ready = grant;
    assign init_done = run;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = sram_dataout;

endmodule

// File: tb/tb_srambank_arb_128x4x74.sv
// Scoreboard bench for srambank_arb_128x4x74 with a behavioural 512x74 bank model.
module tb_srambank_arb_128x4x74;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [8:0]  req_addr0, req_addr1, sram_address;
    logic [73:0] req_wdata0, req_wdata1, rsp_data, sram_wd, sram_dataout;
    logic        init_done, sram_banksel, sram_read, sram_write;

    int n_chk = 0;
    int n_fail = 0;

    logic [73:0] bank_mem [512];
    logic [73:0] bank_q;
    bit          bank_init;
    logic [73:0] ref_mem [512];
    logic [73:0] sb [$];
    logic [1:0]  exp_rsp = 2'b00;

    localparam logic [73:0] W = 74'h3_FFFF_FFFF_FFFF_FFFF;
    localparam logic [73:0] Y = 74'h123_4567_89AB_CDEF_0F0F;
    localparam logic [73:0] Z = 74'h2AA_5555_AAAA_5555_3C3C;

    srambank_arb_128x4x74 dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr0    (req_addr0),
        .req_addr1    (req_addr1),
        .req_wdata0   (req_wdata0),
        .req_wdata1   (req_wdata1),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .init_done    (init_done),
        .sram_banksel (sram_banksel),
        .sram_read    (sram_read),
        .sram_write   (sram_write),
        .sram_address (sram_address),
        .sram_wd      (sram_wd),
        .sram_dataout (sram_dataout)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [73:0] pat(int i);
        return {10'h2A5, 64'hDEAD_BEEF_0000_0000 | 64'(i)};
    endfunction

    // Bank: synchronous 1-cycle read, output holds until the next read.
    always @(posedge clk) begin
        if (!bank_init) begin
            for (int i = 0; i < 512; i++) bank_mem[i] <= pat(i);
            bank_init <= 1'b1;
        end else begin
            if (sram_banksel && sram_write) bank_mem[sram_address] <= sram_wd;
            if (sram_banksel && sram_read) bank_q <= bank_mem[sram_address];
        end
    end
    assign sram_dataout = bank_q;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: models accepted commands and checks every response cycle.
    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
        forever begin
            @(negedge clk);
            if (reset) begin
`ifdef SRAMBANK_ARB_INIT_EN
                for (int i = 0; i < 512; i++) ref_mem[i] = '0;
`endif
                sb.delete();
                exp_rsp = 2'b00;
            end else begin
                check_eq("rsp_valid", rsp_valid, exp_rsp);
                if (exp_rsp != 2'b00 && sb.size() > 0) begin
                    check_eq("rsp_data", rsp_data, sb.pop_front());
                end
                exp_rsp = 2'b00;
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        if (req_write[i]) begin
                            ref_mem[i != 0 ? req_addr1 : req_addr0] = (i != 0) ? req_wdata1
                                                                                : req_wdata0;
                        end else begin
                            sb.push_back(ref_mem[i != 0 ? req_addr1 : req_addr0]);
                            exp_rsp[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr0 = '0;
        req_addr1 = '0;
        req_wdata0 = '0;
        req_wdata1 = '0;
        repeat (3) next_cycle();
        req_valid = 2'b11;
        req_addr0 = 9'h1FF;
        req_addr1 = 9'h100;
        @(negedge clk);
        check_eq("rst_ready", req_ready, 2'b00);
        check_eq("rst_rsp_valid", rsp_valid, 2'b00);
        check_eq("rst_bank_ctl", {sram_banksel, sram_read, sram_write}, 3'b000);
        check_eq("rst_init_done", init_done, 1'b0);
        next_cycle();
        reset = 1'b0;
`ifdef SRAMBANK_ARB_INIT_EN
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            check_eq("fill_addr", sram_address, k);
            check_eq("fill_ctl", {sram_banksel, sram_write, sram_read, req_ready, init_done},
                     6'b110000);
            check_eq("fill_wd", sram_wd, 74'd0);
            next_cycle();
        end
        @(negedge clk);
        check_eq("init_done", init_done, 1'b1);
        check_eq("post_init_grant0", req_ready, 2'b01);
        next_cycle();
        @(negedge clk);
        check_eq("post_init_grant1", req_ready, 2'b10);
        next_cycle();
        req_valid = 2'b00;
`else
        req_valid = 2'b01;
        @(negedge clk);
        check_eq("init_done_first", init_done, 1'b1);
        check_eq("first_ready", req_ready, 2'b01);
        check_eq("first_ctl", {sram_banksel, sram_read, sram_write}, 3'b110);
        check_eq("first_addr", sram_address, 9'h1FF);
        next_cycle();
        req_valid = 2'b00;
`endif
        repeat (2) next_cycle();

        // Requester 0: write then read address 5.
        req_valid = 2'b01; req_write = 2'b01; req_addr0 = 9'd5; req_wdata0 = W;
        @(negedge clk);
        check_eq("wr5_ready", req_ready, 2'b01);
        check_eq("wr5_ctl", {sram_banksel, sram_read, sram_write}, 3'b101);
        check_eq("wr5_addr", sram_address, 9'd5);
        check_eq("wr5_wd", sram_wd, W);
        next_cycle();
        req_write = 2'b00;
        @(negedge clk);
        check_eq("rd5_ready", req_ready, 2'b01);
        check_eq("rd5_ctl", {sram_banksel, sram_read, sram_write}, 3'b110);
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("rd5_rsp_valid", rsp_valid, 2'b01);
        check_eq("rd5_rsp_data", rsp_data, W);
        next_cycle();
        @(negedge clk);
        check_eq("rd5_rsp_one_cycle", rsp_valid, 2'b00);
        next_cycle();

        // Requester 1 write moves prio back to 0.
        req_valid = 2'b10; req_write = 2'b10; req_addr1 = 9'd20; req_wdata1 = Y;
        @(negedge clk);
        check_eq("wr20_ready", req_ready, 2'b10);
        next_cycle();

        // Contention: both read every cycle, grants must alternate starting at 0.
        req_valid = 2'b11; req_write = 2'b00; req_addr0 = 9'd5; req_addr1 = 9'd20;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("rr_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            next_cycle();
        end
        req_valid = 2'b01;
        @(negedge clk);
        check_eq("single_ready", req_ready, 2'b01);
        next_cycle();
        req_valid = 2'b00;
        repeat (2) next_cycle();

        // prio is 1: write from 1 wins, read from 0 follows and sees the new data.
        req_valid = 2'b11; req_write = 2'b10; req_addr0 = 9'd10; req_addr1 = 9'd10;
        req_wdata1 = Z;
        @(negedge clk);
        check_eq("raw_wr_first", req_ready, 2'b10);
        next_cycle();
        req_valid = 2'b01; req_write = 2'b00;
        @(negedge clk);
        check_eq("raw_rd_second", req_ready, 2'b01);
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("raw_rsp_data", rsp_data, Z);
        next_cycle();

        // Reset mid-run drops the pending response.
        req_valid = 2'b01; req_addr0 = 9'd20;
        @(negedge clk);
        check_eq("prerst_ready", req_ready, 2'b01);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("rst_drop_rsp", rsp_valid, 2'b00);
        check_eq("rst_ready_hold", req_ready, 2'b00);
        next_cycle();
        reset = 1'b0;
        req_valid = 2'b00;
`ifdef SRAMBANK_ARB_INIT_EN
        repeat (200) next_cycle();
        @(negedge clk);
        check_eq("mid_fill_addr", sram_address, 9'd200);
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            check_eq("refill_addr0", sram_address, 9'd0);
            while (!init_done && n < 1000) begin
                next_cycle();
                n++;
                @(negedge clk);
            end
            check_eq("refill_len", n, 512);
        end
        next_cycle();
`endif
        req_valid = 2'b01; req_addr0 = 9'd5;
        @(negedge clk);
        check_eq("postrst_ready", req_ready, 2'b01);
        next_cycle();
        req_valid = 2'b00;
        repeat (3) next_cycle();
        check_eq("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
